alu_lane_arbiter: RTL

Two-requester arbiter and sequencer for the shared 6-lane, 32-bit-per-lane ALU (`alu_6lanes`). It accepts operation requests over valid/ready handshakes and grants them round-robin. It drives the registered operands and opcode into the combinational ALU, captures result and zero flag, and returns them to the issuing requester over a valid/ready response channel. It sits between the scalar/vector execute stage (requester 0) and the auxiliary vector engine (requester 1) on one side, and the single ALU instance on the other.

---
 rtl/alu_lane_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_lane_arbiter.sv
// ---------------------------------------------------------------------------
// alu_lane_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter and sequencer in front of the shared
//   6-lane ALU. A request is accepted in IDLE and its operands and opcode are
//   registered onto the ALU inputs. The combinational ALU then evaluates for
//   one cycle (EXEC). Its result and zero flag are captured and returned to
//   the requester that issued it (RESP).
//
// Optional feature (macro ALU_ARB_ILLEGAL_CHK_EN):
//   When defined, a vector request with sel=11 is not issued to the ALU. It
//   is answered with c=0, zero=0, err=1 after the same one-cycle latency.
//   When undefined, every request is issued unchanged and rspN_err is tied
//   to 0.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   reqN_valid/ready          request handshake (N = 0, 1)
//   reqN_op/sel/a/b           request opcode, select and operands
//   rspN_valid/ready          response handshake
//   rspN_c/zero/err           response result, zero flag, illegal-op flag
//   alu_a/b/op/sel            registered operands/opcode driven to the ALU
//   alu_c, alu_zero           combinational ALU result and zero flag
// ---------------------------------------------------------------------------
module alu_lane_arbiter #(
    parameter int  LANES = 6,
    parameter int  LW    = 32,
    localparam int DW    = LANES * LW
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_op,
    input  logic [1:0]    req0_sel,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_op,
    input  logic [1:0]    req1_sel,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_c,
    output logic          rsp0_zero,
    output logic          rsp0_err,

    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_c,
    output logic          rsp1_zero,
    output logic          rsp1_err,

    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_op,
    output logic [1:0]    alu_sel,
    input  logic [DW-1:0] alu_c,
    input  logic          alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          stateQ, stateD;
    logic            ownerQ, ownerD;
    logic            lastQ, lastD;
    logic [DW-1:0]   aluAQ, aluAD;
    logic [DW-1:0]   aluBQ, aluBD;
    logic            aluOpQ, aluOpD;
    logic [1:0]      aluSelQ, aluSelD;
    logic [DW-1:0]   rspCQ, rspCD;
    logic            rspZeroQ, rspZeroD;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    logic            illegalQ, illegalD;
    logic            rspErrQ, rspErrD;
    logic            illegalReq;
`endif

    logic            anyValid;
    logic            grantIdx;
    logic            accept;
    logic            selOp;
    logic [1:0]      selSel;
    logic [DW-1:0]   selA;
    logic [DW-1:0]   selB;
    logic            ownerReady;

    // Grant selection. On a tie the requester not served last wins; with a
    // single valid requester it wins regardless of the pointer. The pointer
    // itself only moves on an accept (see next-state logic).
    always_comb begin
        anyValid   = req0_valid | req1_valid;
        grantIdx   = (req0_valid & req1_valid) ? ~lastQ : req1_valid;
        accept     = (stateQ == ST_IDLE) & anyValid;
        selOp      = grantIdx ? req1_op  : req0_op;
        selSel     = grantIdx ? req1_sel : req0_sel;
        selA       = grantIdx ? req1_a   : req0_a;
        selB       = grantIdx ? req1_b   : req0_b;
        ownerReady = ownerQ ? rsp1_ready : rsp0_ready;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        illegalReq = selOp & (selSel == 2'b11);
`endif
    end

    assign req0_ready = accept & ~grantIdx;
    assign req1_ready = accept &  grantIdx;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence. The ALU
    // registers only change on an issued accept, so they hold their last
    // issued values in every other state.
    always_comb begin
        stateD   = stateQ;
        ownerD   = ownerQ;
        lastD    = lastQ;
        aluAD    = aluAQ;
        aluBD    = aluBQ;
        aluOpD   = aluOpQ;
        aluSelD  = aluSelQ;
        rspCD    = rspCQ;
        rspZeroD = rspZeroQ;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        illegalD = illegalQ;
        rspErrD  = rspErrQ;
`endif
        case (stateQ)
            ST_IDLE: begin
                if (accept) begin
                    ownerD = grantIdx;
                    lastD  = grantIdx;
                    stateD = ST_EXEC;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                    illegalD = illegalReq;
                    if (!illegalReq) begin
                        aluAD   = selA;
                        aluBD   = selB;
                        aluOpD  = selOp;
                        aluSelD = selSel;
                    end
`else
                    aluAD   = selA;
                    aluBD   = selB;
                    aluOpD  = selOp;
                    aluSelD = selSel;
`endif
                end
            end
            ST_EXEC: begin
                stateD = ST_RESP;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                // An illegal request never reached the ALU, so its
                // response is synthesised here instead of captured.
                if (illegalQ) begin
                    rspCD    = '0;
                    rspZeroD = 1'b0;
                    rspErrD  = 1'b1;
                end else begin
                    rspCD    = alu_c;
                    rspZeroD = alu_zero;
                    rspErrD  = 1'b0;
                end
`else
                rspCD    = alu_c;
                rspZeroD = alu_zero;
`endif
            end
            ST_RESP: begin
                if (ownerReady) begin
                    stateD = ST_IDLE;
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight operation and
    // points the round-robin pointer at requester 1 so requester 0 wins the
    // first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= ST_IDLE;
            ownerQ   <= 1'b0;
            lastQ    <= 1'b1;
            aluAQ    <= '0;
            aluBQ    <= '0;
            aluOpQ   <= 1'b0;
            aluSelQ  <= 2'b00;
            rspCQ    <= '0;
            rspZeroQ <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            illegalQ <= 1'b0;
            rspErrQ  <= 1'b0;
`endif
        end else begin
            stateQ   <= stateD;
            ownerQ   <= ownerD;
            lastQ    <= lastD;
            aluAQ    <= aluAD;
            aluBQ    <= aluBD;
            aluOpQ   <= aluOpD;
            aluSelQ  <= aluSelD;
            rspCQ    <= rspCD;
            rspZeroQ <= rspZeroD;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            illegalQ <= illegalD;
            rspErrQ  <= rspErrD;
`endif
        end
    end

    assign alu_a   = aluAQ;
    assign alu_b   = aluBQ;
    assign alu_op  = aluOpQ;
    assign alu_sel = aluSelQ;

    // One response register is shared; only the owner sees valid.
    assign rsp0_valid = (stateQ == ST_RESP) & ~ownerQ;
    assign rsp1_valid = (stateQ == ST_RESP) &  ownerQ;
    assign rsp0_c     = rspCQ;
    assign rsp1_c     = rspCQ;
    assign rsp0_zero  = rspZeroQ;
    assign rsp1_zero  = rspZeroQ;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    assign rsp0_err   = rspErrQ;
    assign rsp1_err   = rspErrQ;
`else
    assign rsp0_err   = 1'b0;
    assign rsp1_err   = 1'b0;
`endif

endmodule
